// File: rtl/mr_regfile_sb.sv
// Integer register file with busy-bit scoreboard and issue hazard check.
// Optional write-back forwarding into hazard check and read ports: MR_REGFILE_BYPASS_EN.
module mr_regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int RSEL = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_write_i,
  input  logic [XLEN-1:0] wb_payload_i,
  input  logic [RSEL-1:0] wb_dst_reg_i,
  input  logic [RSEL-1:0] rd_a_sel_i,
  input  logic [RSEL-1:0] rd_b_sel_i,
  output logic [XLEN-1:0] rd_a_data_o,
  output logic [XLEN-1:0] rd_b_data_o,
  input  logic            iss_valid_i,
  input  logic [RSEL-1:0] iss_dst_reg_i,
  input  logic            iss_use_a_i,
  input  logic            iss_use_b_i,
  output logic            iss_ready_o,
  output logic [RSEL:0]   inflight_o,
  output logic            proto_err_o
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] busy_eff;
  logic [RSEL:0]    inflight_q, inflight_d;
  logic             proto_err_q, proto_err_d;
  logic [XLEN-1:0]  rd_a_q, rd_a_d, rd_b_q, rd_b_d;

  logic wb_en, wb_clears, issue_acc;

  assign wb_en     = wb_write_i && (wb_dst_reg_i != '0);
  assign wb_clears = wb_en && busy_q[wb_dst_reg_i];

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy_eff
    if (gi == 0) begin : g_zero
      assign busy_eff[gi] = 1'b0;
    end else begin : g_reg
`ifdef MR_REGFILE_BYPASS_EN
      // A register retiring this cycle no longer blocks a dependent issue.
      assign busy_eff[gi] = busy_q[gi] & ~(wb_en && (wb_dst_reg_i == RSEL'(gi)));
`else
      assign busy_eff[gi] = busy_q[gi];
`endif
    end
  end

  assign iss_ready_o = !(iss_use_a_i && busy_eff[rd_a_sel_i])
                    && !(iss_use_b_i && busy_eff[rd_b_sel_i])
                    && !busy_eff[iss_dst_reg_i];
  assign issue_acc   = iss_valid_i && iss_ready_o && (iss_dst_reg_i != '0);

  // Clear first, then set: a same-cycle issue to the retiring register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_en)     busy_d[wb_dst_reg_i]  = 1'b0;
    if (issue_acc) busy_d[iss_dst_reg_i] = 1'b1;
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({issue_acc, wb_clears})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  assign proto_err_d = proto_err_q || (wb_en && !busy_q[wb_dst_reg_i]);

  always_comb begin
    rd_a_d = (rd_a_sel_i == '0) ? '0 : regs_q[rd_a_sel_i];
    rd_b_d = (rd_b_sel_i == '0) ? '0 : regs_q[rd_b_sel_i];
`ifdef MR_REGFILE_BYPASS_EN
    if (wb_en && (rd_a_sel_i == wb_dst_reg_i)) rd_a_d = wb_payload_i;
    if (wb_en && (rd_b_sel_i == wb_dst_reg_i)) rd_b_d = wb_payload_i;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q      <= '0;
      inflight_q  <= '0;
      proto_err_q <= 1'b0;
      rd_a_q      <= '0;
      rd_b_q      <= '0;
    end else begin
      if (wb_en) regs_q[wb_dst_reg_i] <= wb_payload_i;
      busy_q      <= busy_d;
      inflight_q  <= inflight_d;
      proto_err_q <= proto_err_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
    end
  end

  assign rd_a_data_o = rd_a_q;
  assign rd_b_data_o = rd_b_q;
  assign inflight_o  = inflight_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_mr_regfile_sb.sv
// Directed bench for mr_regfile_sb; expectations follow MR_REGFILE_BYPASS_EN when defined.
module tb_mr_regfile_sb;

`ifdef MR_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_write_i;
  logic [31:0] wb_payload_i;
  logic [4:0]  wb_dst_reg_i, rd_a_sel_i, rd_b_sel_i, iss_dst_reg_i;
  logic [31:0] rd_a_data_o, rd_b_data_o;
  logic        iss_valid_i, iss_use_a_i, iss_use_b_i, iss_ready_o, proto_err_o;
  logic [5:0]  inflight_o;

  int checks = 0;
  int errors = 0;

  mr_regfile_sb dut (
    .clk(clk), .reset(reset),
    .wb_write_i(wb_write_i), .wb_payload_i(wb_payload_i), .wb_dst_reg_i(wb_dst_reg_i),
    .rd_a_sel_i(rd_a_sel_i), .rd_b_sel_i(rd_b_sel_i),
    .rd_a_data_o(rd_a_data_o), .rd_b_data_o(rd_b_data_o),
    .iss_valid_i(iss_valid_i), .iss_dst_reg_i(iss_dst_reg_i),
    .iss_use_a_i(iss_use_a_i), .iss_use_b_i(iss_use_b_i),
    .iss_ready_o(iss_ready_o), .inflight_o(inflight_o), .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; wb_write_i = 1'b0; wb_payload_i = '0; wb_dst_reg_i = '0;
    rd_a_sel_i = '0; rd_b_sel_i = '0; iss_valid_i = 1'b0; iss_dst_reg_i = '0;
    iss_use_a_i = 1'b0; iss_use_b_i = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset state
    rd_a_sel_i = 5'd5;
    step();
    check("reset_rd_a5", rd_a_data_o, 32'h0);
    check("reset_ready", {31'b0, iss_ready_o}, 32'h1);
    check("reset_inflight", {26'b0, inflight_o}, 32'h0);
    check("reset_proto", {31'b0, proto_err_o}, 32'h0);

    // Issue dst 7, then a dependent issue stalls until writeback of 7
    iss_valid_i = 1'b1; iss_dst_reg_i = 5'd7;
    #1 check("iss7_ready", {31'b0, iss_ready_o}, 32'h1);
    step();
    iss_valid_i = 1'b0; iss_dst_reg_i = '0;
    check("iss7_inflight", {26'b0, inflight_o}, 32'h1);
    iss_use_a_i = 1'b1; rd_a_sel_i = 5'd7;
    #1 check("dep7_stall", {31'b0, iss_ready_o}, 32'h0);
    step();
    check("dep7_stall_hold", {31'b0, iss_ready_o}, 32'h0);
    wb_write_i = 1'b1; wb_dst_reg_i = 5'd7; wb_payload_i = 32'hDEADBEEF;
    #1 check("dep7_ready_wb", {31'b0, iss_ready_o}, {31'b0, BYP});
    step();
    wb_write_i = 1'b0;
    check("wb7_rd_same_edge", rd_a_data_o, BYP ? 32'hDEADBEEF : 32'h0);
    check("wb7_ready_after", {31'b0, iss_ready_o}, 32'h1);
    check("wb7_inflight", {26'b0, inflight_o}, 32'h0);
    step();
    check("rd7_deadbeef", rd_a_data_o, 32'hDEADBEEF);

    // Same-cycle writeback of 7 and dependent issue (dst 8)
    iss_use_a_i = 1'b0;
    iss_valid_i = 1'b1; iss_dst_reg_i = 5'd7;
    step();
    check("reiss7_inflight", {26'b0, inflight_o}, 32'h1);
    iss_use_a_i = 1'b1; rd_a_sel_i = 5'd7; iss_dst_reg_i = 5'd8;
    wb_write_i = 1'b1; wb_dst_reg_i = 5'd7; wb_payload_i = 32'h12345678;
    #1 check("same_cyc_ready", {31'b0, iss_ready_o}, {31'b0, BYP});
    step();
    wb_write_i = 1'b0;
    if (BYP) begin
      iss_valid_i = 1'b0;
      check("byp_inflight", {26'b0, inflight_o}, 32'h1);
      check("byp_rd_fwd", rd_a_data_o, 32'h12345678);
    end else begin
      check("nobyp_inflight_stall", {26'b0, inflight_o}, 32'h0);
      check("nobyp_rd_old", rd_a_data_o, 32'hDEADBEEF);
      check("nobyp_ready_next", {31'b0, iss_ready_o}, 32'h1);
      step();
      iss_valid_i = 1'b0;
      check("nobyp_inflight_acc", {26'b0, inflight_o}, 32'h1);
      check("nobyp_rd_new", rd_a_data_o, 32'h12345678);
    end
    iss_use_a_i = 1'b0; iss_dst_reg_i = '0;
    wb_write_i = 1'b1; wb_dst_reg_i = 5'd8; wb_payload_i = 32'hA5A5A5A5;
    step();
    wb_write_i = 1'b0;
    check("wb8_inflight", {26'b0, inflight_o}, 32'h0);
    check("wb8_proto", {31'b0, proto_err_o}, 32'h0);

    // Writeback to register 0 is dropped
    wb_write_i = 1'b1; wb_dst_reg_i = 5'd0; wb_payload_i = 32'hFFFFFFFF;
    step();
    wb_write_i = 1'b0;
    rd_a_sel_i = 5'd0; rd_b_sel_i = 5'd8;
    step();
    check("rd0_zero", rd_a_data_o, 32'h0);
    check("rd_b8", rd_b_data_o, 32'hA5A5A5A5);
    check("wb0_proto", {31'b0, proto_err_o}, 32'h0);

    // Writeback to idle register 3: sticky protocol error, write commits
    wb_write_i = 1'b1; wb_dst_reg_i = 5'd3; wb_payload_i = 32'h00000033;
    step();
    wb_write_i = 1'b0;
    check("wb3_proto", {31'b0, proto_err_o}, 32'h1);
    check("wb3_inflight", {26'b0, inflight_o}, 32'h0);
    rd_a_sel_i = 5'd3;
    step(); step();
    check("rd3_value", rd_a_data_o, 32'h00000033);
    check("proto_sticky", {31'b0, proto_err_o}, 32'h1);

    // Issue dst 9 then reset
    iss_valid_i = 1'b1; iss_dst_reg_i = 5'd9;
    step();
    iss_valid_i = 1'b0;
    check("iss9_inflight", {26'b0, inflight_o}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst9_inflight", {26'b0, inflight_o}, 32'h0);
    check("rst9_proto", {31'b0, proto_err_o}, 32'h0);
    #1 check("rst9_ready", {31'b0, iss_ready_o}, 32'h1);
    step();
    check("rst_rd3_cleared", rd_a_data_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mr_regfile_sb.md
# mr_regfile_sb

Integer register file plus scoreboard for the in-order core, sitting directly downstream of the load/store stage. It consumes the writeback bundle (write strobe, payload, destination register), commits it to the architectural registers, and clears the destination's busy bit. Toward decode it provides two registered read ports and an issue handshake that stalls while any source or destination register still has a load or store in flight.

## Interface
- XLEN, default 32: data width.
- NREGS, default 32: architectural registers; register 0 is hardwired zero.
- RSEL = $clog2(NREGS): derived select width, not overridable.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- wb_write_i  in  1  writeback strobe, single-cycle, no backpressure.
- wb_payload_i  in  XLEN  writeback data.
- wb_dst_reg_i  in  RSEL  writeback destination.
- rd_a_sel_i / rd_b_sel_i  in  RSEL  read-port selects, sampled every cycle.
- rd_a_data_o / rd_b_data_o  out  XLEN  registered read data.
- iss_valid_i  in  1  decode presents an instruction.
- iss_dst_reg_i  in  RSEL  destination it will write (0 = none).
- iss_use_a_i / iss_use_b_i  in  1  source A/B actually read.
- iss_ready_o  out  1  combinational; no hazard, issue accepted this cycle.
- inflight_o  out  RSEL+1  number of busy registers.
- proto_err_o  out  1  sticky; writeback to a non-busy, non-zero register.

## Operation
- State: regs[1..NREGS-1] (XLEN each), busy[NREGS-1:0], inflight counter, proto_err flag.
- Writeback: when wb_write_i and wb_dst_reg_i != 0, regs[dst] <= payload and busy[dst] <= 0. A write to register 0 is dropped and does not set proto_err. If busy[dst] was already 0, proto_err_o <= 1; the write still commits.
- Hazard: iss_ready_o = !(iss_use_a_i & busy_eff[rd_a_sel_i]) & !(iss_use_b_i & busy_eff[rd_b_sel_i]) & !busy_eff[iss_dst_reg_i]. busy_eff[0] is always 0. iss_ready_o is independent of iss_valid_i.
- Issue: on iss_valid_i & iss_ready_o with iss_dst_reg_i != 0, busy[dst] <= 1.
- inflight: +1 on an accepted issue with nonzero destination; -1 on a writeback that clears a busy bit. When both occur in the same cycle the count is unchanged. The count saturates at neither end; proto_err flags any misuse.
- Reads: rd_x_data_o <= (sel == 0) ? 0 : regs[sel], one cycle after the select is presented.

## Timing
- Reset, held for one or more cycles: all regs = 0, busy = 0, inflight_o = 0, proto_err_o = 0, rd_a/b_data_o = 0. iss_ready_o reads 1 because all busy bits are clear. Reset overrides every same-cycle writeback or issue.
- Read latency: 1 cycle from select to data.
- Writeback-to-busy-clear: busy clears at the edge where wb_write_i is sampled. Without bypass, an issue blocked on that register is accepted the following cycle.
- Same-cycle writeback and issue to the same register: the issue sees the pre-clear busy and stalls (non-bypass). Busy therefore never sets and clears in one edge.
- Writeback and register read on the same edge without bypass: the read returns the old value.

## Configuration
- MR_REGFILE_BYPASS_EN defined:
  - busy_eff[r] = busy[r] & !(wb_write_i & wb_dst_reg_i == r). A register being written back this cycle counts as not busy, so the dependent issue is accepted one cycle earlier.
  - Read ports forward wb_payload_i when the select equals a nonzero wb_dst_reg_i.
  - A same-cycle writeback and issue to the same register leaves busy = 1 (the issue wins); inflight is unchanged.
- MR_REGFILE_BYPASS_EN undefined: busy_eff = busy, no forwarding, timing as above.

## Test plan
- Reset, then read sel 5 → rd_a_data_o = 0; iss_ready_o = 1; inflight_o = 0.
- Issue with dst = 7 → next cycle busy[7] set, inflight_o = 1. Then issue with use_a and rd_a_sel = 7 → iss_ready_o = 0 until a writeback of 7 with payload 0xDEADBEEF. Read of 7 afterwards → 0xDEADBEEF.
- Same-cycle writeback of 7 (payload 0x12345678) and dependent issue on 7:
  - Bypass off: stalls one cycle.
  - Bypass on: accepted that cycle, and rd_a_data_o = 0x12345678 on the next cycle.
- Writeback to register 0 with payload 0xFFFFFFFF → read of 0 still returns 0; proto_err_o stays 0.
- Writeback to idle register 3 → proto_err_o = 1 and stays 1 until reset; regs[3] is updated.
- Issue dst = 9 and assert reset on the next cycle → busy[9] = 0, inflight_o = 0, iss_ready_o = 1.
